instr_prefetch_queue: RTL and testbench
=======================================

// Module: instr_prefetch_queue
// PURPOSE
//   Fetch stage directly upstream of the single-cycle core's decode and execute path.
//   Issues sequential word fetches to the instruction memory over a req/gnt/rvalid handshake.
//   Buffers the returned 16-bit instructions, each with its PC, in a small in-order queue.
//   Presents one instruction per cycle to the core; a core redirect (branch or jump) flushes the queue.
// PARAMETERS
//   ADDR_W    16       instruction address width; memory is word-addressed, PC step is +1
//   INST_W    16       instruction width
//   DEPTH     4        queue entries, power of 2, >=2; also the cap on outstanding + buffered fetches
//   RESET_PC  16'h0000 first fetch address after reset
// PORTS
//   clk          in   1       clock, rising edge
//   reset        in   1       asynchronous, active-high reset
//   imem_req     out  1       fetch request; held until imem_gnt
//   imem_addr    out  ADDR_W  fetch address; stable while imem_req=1 and imem_gnt=0
//   imem_gnt     in   1       request accepted this cycle
//   imem_rvalid  in   1       read data valid; in order, >=1 cycle after the matching gnt
//   imem_rdata   in   INST_W  read data
//   inst_valid   out  1       queue head valid
//   inst         out  INST_W  head instruction
//   inst_pc      out  ADDR_W  head PC
//   inst_ready   in   1       core consumes head when inst_valid=1
//   redirect     in   1       flush the queue and restart fetching at redirect_pc
//   redirect_pc  in   ADDR_W  new fetch address
// BEHAVIOUR
//   - Reset values: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0,
//     queue empty, outstanding=0, drop=0, state=FETCH.
//   - Request issue: on any FETCH-state cycle where (count+outstanding)<DEPTH and no request is
//     pending, imem_req is registered high and imem_addr = fetch_pc. First request appears
//     1 cycle after reset release.
//   - Grant: outstanding++ and fetch_pc++ (wraps modulo 2^ADDR_W); imem_req drops for one cycle
//     unless a further slot is free. In that case back-to-back requests are allowed, with the
//     address already advanced.
//   - Return: imem_rvalid with drop=0 pushes {pc,rdata} and decrements outstanding. Entry visible
//     on inst_valid the cycle after rvalid, so fetch-to-visible latency = mem latency + 1.
//   - Pop: inst_valid & inst_ready advances the head; push and pop in the same cycle keep count.
//   - Full: count+outstanding==DEPTH suppresses new requests; no data is ever lost or overwritten.
//   - Empty: inst_valid=0; inst/inst_pc hold their last values and are don't-care to the core.
//   - States: FETCH, DRAIN.
//       FETCH --redirect--> DRAIN if outstanding (incl. a same-cycle gnt, excl. a same-cycle
//         rvalid) > 0, else stays in FETCH.
//       On redirect: queue flushed, fetch_pc=redirect_pc, imem_req cleared (a pending
//         un-granted request is withdrawn), drop=outstanding.
//       DRAIN: no requests; each rvalid is discarded and decrements drop and outstanding;
//         drop==0 -> FETCH.
//       Redirect while in DRAIN: fetch_pc reloaded, stay in DRAIN.
//   - Simultaneous events: redirect+pop -> pop ignored (the core kills it); redirect+rvalid ->
//     data discarded; redirect+gnt -> granted fetch counted into drop.
//   - Reset mid-operation: all state cleared at once; the memory must also be reset, as stale
//     rvalids are not tracked.
// CONFIGURATION
//   PREFETCH_STATS_EN defined: adds two ports, both reset to 0 and saturating at all-ones:
//     stall_cycles out 32  count of FETCH cycles with inst_ready=1 and inst_valid=0
//     flush_count  out 32  count of redirect cycles
//   Undefined: ports and counters absent; the rest of the behaviour is unchanged.
// STRUCTURE
//   - Package pf_pkg: state enum {PF_FETCH, PF_DRAIN}; default ADDR_W/INST_W/DEPTH constants;
//     entry struct {pc, inst}.
//   - Sub-module pf_fifo: synchronous show-ahead FIFO with push/pop/flush, count output, and
//     $clog2(DEPTH)+1-bit pointers.
//   - Top level holds the FSM, fetch_pc, and the outstanding/drop counters, each
//     $clog2(DEPTH+1) bits wide.
// TESTING
//   1. Reset release, gnt=1, 1-cycle memory, inst_ready=1 -> imem_addr 0,1,2,3,...;
//      first inst_valid 2 cycles after the first gnt, with inst_pc=0.
//   2. inst_ready=0, DEPTH=4 -> exactly 4 grants, then imem_req=0; one pop -> exactly one new
//      request at addr 4.
//   3. 2 fetches outstanding, redirect with redirect_pc=16'h0040 -> next 2 rvalids dropped,
//      inst_valid stays 0; next imem_addr=16'h0040; first delivered inst_pc=16'h0040.
//   4. gnt withheld 3 cycles -> imem_addr stable, no duplicate grant, PC sequence unbroken.
//   5. Fetch at 16'hFFFF -> next address 16'h0000. Assert reset mid-burst -> outputs return to
//      reset values in the same cycle.
//   6. With PREFETCH_STATS_EN: 3 empty-queue cycles with inst_ready=1 and 2 redirects ->
//      stall_cycles>=3 and flush_count=2. Without the macro the design builds with no
//      stats ports.

Source files
------------

// File: rtl/pf_pkg.sv
// Shared types and default sizes for the instruction prefetch queue.
package pf_pkg;

    localparam int PF_ADDR_W = 16;
    localparam int PF_INST_W = 16;
    localparam int PF_DEPTH  = 4;

    typedef enum logic {
        PF_FETCH = 1'b0,
        PF_DRAIN = 1'b1
    } pf_state_e;

    typedef struct packed {
        logic [PF_ADDR_W-1:0] pc;
        logic [PF_INST_W-1:0] inst;
    } pf_entry_t;

endpackage

// File: rtl/instr_prefetch_queue_if.sv
// Instruction-memory and core-side signals of the prefetch queue.
interface instr_prefetch_queue_if #(
    parameter int ADDR_W = 16,
    parameter int INST_W = 16
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [INST_W-1:0] imem_rdata;
    logic              inst_valid;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_gnt, imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/pf_fifo.sv
// Show-ahead FIFO with flush; pointers carry one extra wrap bit so full and empty differ.
module pf_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [WIDTH-1:0]       data_i,
    output logic [WIDTH-1:0]       data_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = 1;

    logic [PW:0]      wr_q, rd_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else if (flush_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + PTR_ONE;
            if (pop_i && count_o != '0) rd_q <= rd_q + PTR_ONE;
        end
    end

    // Storage is never reset; only the pointers define which words are live.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_q[PW-1:0]] <= data_i;
    end

    assign data_o  = mem_q[rd_q[PW-1:0]];
    assign count_o = wr_q - rd_q;

endmodule

// File: rtl/instr_prefetch_queue.sv
// Sequential instruction prefetcher with in-order queue and redirect flush.
// Define PREFETCH_STATS_EN to add the stall_cycles / flush_count counters.
module instr_prefetch_queue
    import pf_pkg::*;
#(
    parameter int                ADDR_W   = PF_ADDR_W,
    parameter int                INST_W   = PF_INST_W,
    parameter int                DEPTH    = PF_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    instr_prefetch_queue_if.master bus
`ifdef PREFETCH_STATS_EN
    ,
    output logic [31:0]            stall_cycles,
    output logic [31:0]            flush_count
`endif
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 2;
    localparam int EW = ADDR_W + INST_W;

    pf_state_e             state_q, state_d;
    logic [ADDR_W-1:0]     fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]     ret_pc_q, ret_pc_d;
    logic                  req_q, req_d;
    logic [CW-1:0]         outst_q, outst_d;
    logic [CW-1:0]         drop_q, drop_d;
    logic [EW-1:0]         last_q;
    logic [EW-1:0]         head;
    logic [$clog2(DEPTH):0] fifo_cnt;
    logic [SW-1:0]         inflight;
    logic                  gnt_acc, push, pop, flush;

    assign gnt_acc  = req_q & bus.imem_gnt;
    assign inflight = SW'(fifo_cnt) + SW'(outst_q) + SW'(gnt_acc);
    assign pop      = bus.inst_valid & bus.inst_ready;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        ret_pc_d   = ret_pc_q;
        req_d      = req_q;
        outst_d    = outst_q + CW'(gnt_acc) - CW'(bus.imem_rvalid);
        drop_d     = drop_q;
        push       = 1'b0;
        flush      = 1'b0;

        if (gnt_acc) fetch_pc_d = fetch_pc_q + ADDR_W'(1);

        if (bus.redirect) begin
            // Everything still in flight, including a grant taken this cycle, is stale.
            flush      = 1'b1;
            fetch_pc_d = bus.redirect_pc;
            ret_pc_d   = bus.redirect_pc;
            req_d      = 1'b0;
            drop_d     = outst_d;
            state_d    = (state_q == PF_DRAIN || outst_d != '0) ? PF_DRAIN : PF_FETCH;
        end else if (state_q == PF_FETCH) begin
            if (bus.imem_rvalid) begin
                push     = 1'b1;
                ret_pc_d = ret_pc_q + ADDR_W'(1);
            end
            if (!req_q || bus.imem_gnt) req_d = (inflight < SW'(DEPTH));
        end else begin
            req_d = 1'b0;
            if (bus.imem_rvalid) drop_d = drop_q - CW'(1);
            if (drop_d == '0) state_d = PF_FETCH;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= PF_FETCH;
            fetch_pc_q <= RESET_PC;
            ret_pc_q   <= RESET_PC;
            req_q      <= 1'b0;
            outst_q    <= '0;
            drop_q     <= '0;
            last_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            ret_pc_q   <= ret_pc_d;
            req_q      <= req_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            if (bus.inst_valid) last_q <= head;
        end
    end

    pf_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .data_i  ({ret_pc_q, bus.imem_rdata}),
        .data_o  (head),
        .count_o (fifo_cnt)
    );

    assign bus.imem_req   = req_q;
    assign bus.imem_addr  = fetch_pc_q;
    assign bus.inst_valid = (fifo_cnt != '0);
    // When empty, keep showing the last head so the outputs do not wander.
    assign {bus.inst_pc, bus.inst} = bus.inst_valid ? head : last_q;

`ifdef PREFETCH_STATS_EN
    logic [31:0] stall_q, flush_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q     <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (state_q == PF_FETCH && bus.inst_ready && !bus.inst_valid && stall_q != '1)
                stall_q <= stall_q + 32'd1;
            if (bus.redirect && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Randomized scoreboard bench for instr_prefetch_queue with an epoch-based fetch model.
module tb_instr_prefetch_queue;
    import pf_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    instr_prefetch_queue_if #(.ADDR_W(PF_ADDR_W), .INST_W(PF_INST_W)) bus();

`ifdef PREFETCH_STATS_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    instr_prefetch_queue #(
        .ADDR_W   (PF_ADDR_W),
        .INST_W   (PF_INST_W),
        .DEPTH    (4),
        .RESET_PC (16'h0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef PREFETCH_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`endif
    );

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        int          tag;
        int          due;
    } mreq_t;

    mreq_t      mem_q[$];
    pf_entry_t  exp_q[$];
    pf_entry_t  staged[$];

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          last_due = 0;
    int          n_gnt = 0;
    int          first_gnt_cyc = -1;
    int          first_vld_cyc = -1;
    logic [15:0] model_pc = 16'h0000;
    logic [15:0] prev_addr = 16'h0000;
    logic [15:0] last_gnt_addr = 16'h0000;
    logic [15:0] cap_pc = 16'hDEAD;
    bit          prev_hold = 1'b0;
    bit          in_reset = 1'b1;
    bit          wrap_seen = 1'b0;
    bit          cap_first = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        in_reset = 1'b1;
        reset = 1'b1;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 16'h0000;
        bus.inst_ready  = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 16'h0000;
        #1;
        chk("rst_req", bus.imem_req, 0);
        chk("rst_addr", bus.imem_addr, 16'h0000);
        chk("rst_valid", bus.inst_valid, 0);
        chk("rst_inst", bus.inst, 0);
        chk("rst_pc", bus.inst_pc, 0);
        mem_q.delete();
        exp_q.delete();
        staged.delete();
        epoch = 0;
        model_pc = 16'h0000;
        last_due = 0;
        n_gnt = 0;
        prev_hold = 1'b0;
        first_gnt_cyc = -1;
        first_vld_cyc = -1;
        wrap_seen = 1'b0;
        last_gnt_addr = 16'h0000;
        cap_first = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        in_reset = 1'b0;
        @(posedge clk);
        #1;
        chk("first_req", bus.imem_req, 1);
        chk("first_addr", bus.imem_addr, 16'h0000);
    endtask

    // One clock of stimulus; percentages for gnt/ready/redirect, memory latency range.
    task automatic step(input int gp, input int rp, input int xp, input int lo, input int hi,
                        input bit fr, input logic [15:0] fpc);
        logic        req;
        logic [15:0] addr, xpc;
        bit          g, r, x, rv, stale;
        mreq_t       e;
        int          lat;
        @(negedge clk);
        cyc++;
        while (staged.size() > 0) exp_q.push_back(staged.pop_front());
        req  = bus.imem_req;
        addr = bus.imem_addr;
        if (bus.inst_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (prev_hold) begin
            chk("req_hold", req, 1);
            chk("addr_stable", addr, prev_addr);
        end
        stale = 1'b0;
        foreach (mem_q[i]) if (mem_q[i].tag != epoch) stale = 1'b1;
        if (stale) chk("req_in_drain", req, 0);

        g   = ($urandom_range(99) < gp);
        r   = ($urandom_range(99) < rp);
        x   = fr || ($urandom_range(99) < xp);
        xpc = fr ? fpc : (($urandom_range(3) == 0) ? 16'hFFFC + 16'($urandom_range(3))
                                                   : 16'($urandom));
        rv  = (mem_q.size() > 0) && (mem_q[0].due <= cyc);

        bus.imem_gnt    = g;
        bus.inst_ready  = r;
        bus.redirect    = x;
        bus.redirect_pc = xpc;
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rv ? mem_q[0].data : 16'($urandom);

        if (rv) begin
            e = mem_q.pop_front();
            if (e.tag == epoch + int'(x)) staged.push_back('{pc: e.addr, inst: e.data});
        end
        if (req && g) begin
            chk("gnt_addr", addr, model_pc);
            if (addr == 16'h0000 && last_gnt_addr == 16'hFFFF) wrap_seen = 1'b1;
            last_gnt_addr = addr;
            if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
            n_gnt++;
            lat    = $urandom_range(hi, lo);
            e.addr = model_pc;
            e.data = 16'($urandom);
            e.tag  = epoch;
            e.due  = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            last_due = e.due;
            mem_q.push_back(e);
            model_pc = model_pc + 16'd1;
        end
        if (x) begin
            epoch++;
            model_pc = xpc;
        end
        prev_hold = req && !g && !x;
        prev_addr = addr;
    endtask

    // Monitor: compares the presented head with the scoreboard and retires consumed entries.
    always @(negedge clk) begin
        #1;
        if (!in_reset) begin
            chk("inst_valid", bus.inst_valid, exp_q.size() != 0);
            if (bus.inst_valid && exp_q.size() != 0) begin
                chk("inst_pc", bus.inst_pc, exp_q[0].pc);
                chk("inst", bus.inst, exp_q[0].inst);
                if (cap_first) begin
                    cap_pc = bus.inst_pc;
                    cap_first = 1'b0;
                end
            end
            if (bus.redirect) exp_q.delete();
            else if (bus.inst_valid && bus.inst_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        end
    end

    initial begin
        #2;
        // Streaming with a one-cycle memory.
        do_reset();
        repeat (8) step(100, 100, 0, 1, 1, 1'b0, 16'h0);
        chk("first_vld_lat", first_vld_cyc - first_gnt_cyc, 2);

        // Queue fills while the core stalls.
        do_reset();
        repeat (12) step(100, 0, 0, 1, 1, 1'b0, 16'h0);
        chk("full_gnts", n_gnt, 4);
        chk("full_req", bus.imem_req, 0);
        step(100, 100, 0, 1, 1, 1'b0, 16'h0);
        repeat (8) step(100, 0, 0, 1, 1, 1'b0, 16'h0);
        chk("refill_gnts", n_gnt, 5);
        chk("refill_addr", last_gnt_addr, 16'h0004);
        chk("refill_req", bus.imem_req, 0);

        // Redirect with two fetches in flight.
        do_reset();
        repeat (2) step(100, 100, 0, 4, 4, 1'b0, 16'h0);
        step(0, 100, 0, 4, 4, 1'b1, 16'h0040);
        cap_first = 1'b1;
        cap_pc = 16'hDEAD;
        repeat (16) step(100, 100, 0, 4, 4, 1'b0, 16'h0);
        chk("redir_first_pc", cap_pc, 16'h0040);

        // Grant withheld.
        do_reset();
        repeat (3) step(0, 100, 0, 1, 2, 1'b0, 16'h0);
        chk("withheld_gnts", n_gnt, 0);
        step(100, 100, 0, 1, 2, 1'b0, 16'h0);
        chk("late_gnt", n_gnt, 1);
        chk("late_gnt_addr", last_gnt_addr, 16'h0000);
        repeat (20) step(40, 100, 0, 1, 2, 1'b0, 16'h0);

        // Address wrap, then reset in the middle of the burst.
        do_reset();
        step(0, 100, 0, 1, 1, 1'b1, 16'hFFFE);
        repeat (10) step(100, 100, 0, 1, 1, 1'b0, 16'h0);
        chk("addr_wrap", wrap_seen, 1);
        #2;
        do_reset();

`ifdef PREFETCH_STATS_EN
        repeat (4) step(0, 100, 0, 1, 1, 1'b0, 16'h0);
        chk("stall_min", stall_cycles >= 32'd3, 1);
        step(0, 100, 0, 1, 1, 1'b1, 16'h0100);
        step(0, 100, 0, 1, 1, 1'b1, 16'h0200);
        step(0, 100, 0, 1, 1, 1'b0, 16'h0);
        chk("flush_count", flush_count, 2);
        do_reset();
`endif

        // Randomized traffic in three flavours.
        repeat (1500) step(70, 60, 3, 1, 4, 1'b0, 16'h0);
        repeat (1500) step(95, 30, 2, 1, 3, 1'b0, 16'h0);
        repeat (1500) step(50, 90, 5, 1, 5, 1'b0, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
